// File: rtl/seq_muldivmod.sv
// Multi-cycle unsigned divide / modulo / multiply unit with valid/ready handshakes.
// Optional MULDIV_POW2_FASTPATH_EN: power-of-two b resolves in one cycle instead of WIDTH.
module seq_muldivmod #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_DIV = 2'd0;
    localparam logic [1:0] MODE_MOD = 2'd1;
    localparam logic [1:0] MODE_MUL = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         mode_reg, mode_next;
    // opa: dividend shifting into quotient (div/mod) or multiplicand shifting left (mul)
    logic [WIDTH-1:0]   opa_reg, opa_next;
    // opb: divisor (constant during RUN) or multiplier shifting right
    logic [WIDTH-1:0]   opb_reg, opb_next;
    // work: partial remainder (div/mod) or product accumulator (mul)
    logic [WIDTH-1:0]   work_reg, work_next;
    logic [WIDTH-1:0]   y_reg, y_next;
    logic               dbz_reg, dbz_next;

    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   acc_step;

`ifdef MULDIV_POW2_FASTPATH_EN
    localparam int LG_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // Mask of bit positions whose index has bit k set; OR-ing b under it encodes log2 of a one-hot b.
    function automatic logic [WIDTH-1:0] index_mask(input int k);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = ((i >> k) & 1) == 1;
        end
        return m;
    endfunction

    logic [LG_W-1:0]  b_log2;
    logic             b_pow2;
    logic [WIDTH-1:0] fast_y;

    generate
        for (genvar gi = 0; gi < LG_W; gi++) begin : g_log2
            localparam logic [WIDTH-1:0] MASK = index_mask(gi);
            assign b_log2[gi] = |(b & MASK);
        end
    endgenerate

    assign b_pow2 = (b != '0) && ((b & (b - WIDTH'(1))) == '0);

    always_comb begin
        fast_y = '0;
        case (mode)
            MODE_DIV: fast_y = a >> b_log2;
            MODE_MOD: fast_y = a & (b - WIDTH'(1));
            MODE_MUL: fast_y = a << b_log2;
            default:  fast_y = '0;
        endcase
    end
`endif

    // One restoring-division step: the partial remainder is WIDTH+1 bits after the shift.
    // When rem_ge holds the true difference is below b, so WIDTH-bit modular subtraction is exact.
    assign rem_shift = {work_reg, opa_reg[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, opb_reg};
    assign rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - opb_reg) : rem_shift[WIDTH-1:0];
    assign quo_step  = {opa_reg[WIDTH-2:0], rem_ge};

    // One shift-add multiply step, LSB of the multiplier first, truncated to WIDTH bits.
    assign acc_step  = work_reg + (opb_reg[0] ? opa_reg : '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        work_next  = work_reg;
        y_next     = y_reg;
        dbz_next   = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    mode_next = mode;
                    opa_next  = a;
                    opb_next  = b;
                    work_next = '0;
                    if (mode == MODE_RSV) begin
                        y_next     = '0;
                        dbz_next   = 1'b0;
                        state_next = DONE;
                    end else if ((mode != MODE_MUL) && (b == '0)) begin
                        y_next     = (mode == MODE_DIV) ? '1 : a;
                        dbz_next   = 1'b1;
                        state_next = DONE;
`ifdef MULDIV_POW2_FASTPATH_EN
                    end else if (b_pow2) begin
                        y_next     = fast_y;
                        dbz_next   = 1'b0;
                        state_next = DONE;
`endif
                    end else begin
                        cnt_next   = CNT_W'(WIDTH);
                        state_next = RUN;
                    end
                end
            end

            RUN: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (mode_reg == MODE_MUL) begin
                    work_next = acc_step;
                    opa_next  = opa_reg << 1;
                    opb_next  = opb_reg >> 1;
                end else begin
                    work_next = rem_step;
                    opa_next  = quo_step;
                end
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                    dbz_next   = 1'b0;
                    case (mode_reg)
                        MODE_MUL: y_next = acc_step;
                        MODE_DIV: y_next = quo_step;
                        default:  y_next = rem_step;
                    endcase
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= MODE_DIV;
            opa_reg   <= '0;
            opb_reg   <= '0;
            work_reg  <= '0;
            y_reg     <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            work_reg  <= work_next;
            y_reg     <= y_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign y         = y_reg;
    assign dbz       = dbz_reg;

endmodule

// File: tb/tb_seq_muldivmod.sv
// Randomized self-checking bench for seq_muldivmod against an arithmetic reference model.
module tb_seq_muldivmod;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         dbz;

    int n_checks = 0;
    int n_errors = 0;

    seq_muldivmod #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition.
    function automatic logic [W-1:0] model_y(input logic [1:0] m, input logic [W-1:0] av,
                                             input logic [W-1:0] bv);
        int p;
        case (m)
            2'd0: model_y = (bv == 0) ? {W{1'b1}} : W'(int'(av) / int'(bv));
            2'd1: model_y = (bv == 0) ? av : W'(int'(av) % int'(bv));
            2'd2: begin
                p = int'(av) * int'(bv);
                model_y = W'(p);
            end
            default: model_y = '0;
        endcase
    endfunction

    function automatic logic model_dbz(input logic [1:0] m, input logic [W-1:0] bv);
        return (m < 2'd2) && (bv == 0);
    endfunction

    // Clock edges after the accept edge before out_valid is seen.
    function automatic int model_lat(input logic [1:0] m, input logic [W-1:0] bv);
        if (m == 2'd3 || (m < 2'd2 && bv == 0)) return 0;
`ifdef MULDIV_POW2_FASTPATH_EN
        if ($countones(bv) == 1) return 0;
`endif
        return W;
    endfunction

    // Accept one request, scramble inputs afterwards, and wait (bounded) for out_valid.
    task automatic issue(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int edges);
        check("in_ready_before_accept", in_ready, 1);
        mode = m; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode = 2'($urandom); a = W'($urandom); b = W'($urandom);
        edges = 0;
        while (!out_valid && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_drain", out_valid, 0);
        check("in_ready_after_drain", in_ready, 1);
    endtask

    task automatic op(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] exp_y, input logic exp_dbz, input int exp_lat);
        int edges;
        issue(m, av, bv, edges);
        check("latency", edges, exp_lat);
        check("out_valid", out_valid, 1);
        check("y", y, exp_y);
        check("dbz", dbz, exp_dbz);
        $display("op mode=%0d a=%0d b=%0d -> y=%0d dbz=%0d edges=%0d", m, av, bv, y, dbz, edges);
        drain();
    endtask

    task automatic op_model(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv);
        op(m, av, bv, model_y(m, av, bv), model_dbz(m, bv), model_lat(m, bv));
    endtask

    initial begin
        int edges;
        int pow2_lat;
        logic [1:0]   rm;
        logic [W-1:0] ra, rb;

`ifdef MULDIV_POW2_FASTPATH_EN
        pow2_lat = 0;
`else
        pow2_lat = W;
`endif
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 2'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_dbz", dbz, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        op(2'd0, 8'd200, 8'd7, 8'd28, 1'b0, W);
        op(2'd1, 8'd200, 8'd7, 8'd4, 1'b0, W);
        op(2'd0, 8'd200, 8'd0, 8'd255, 1'b1, 0);
        op(2'd1, 8'd200, 8'd0, 8'd200, 1'b1, 0);
        op(2'd2, 8'd37, 8'd8, 8'd40, 1'b0, pow2_lat);
        op(2'd2, 8'd255, 8'd255, 8'd1, 1'b0, W);
        op(2'd3, 8'd55, 8'd66, 8'd0, 1'b0, 0);
        op(2'd0, 8'd255, 8'd1, 8'd255, 1'b0, pow2_lat);
        op(2'd1, 8'd201, 8'd128, 8'd73, 1'b0, pow2_lat);
        op(2'd0, 8'd5, 8'd200, 8'd0, 1'b0, W);
        op(2'd1, 8'd255, 8'd255, 8'd0, 1'b0, W);
        op(2'd2, 8'd0, 8'd0, 8'd0, 1'b0, W);

        // Backpressure: result held, no new accepts while DONE.
        issue(2'd0, 8'd200, 8'd7, edges);
        check("bp_latency", edges, W);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mode = 2'd2; a = 8'd3; b = 8'd3; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_out_valid", out_valid, 1);
            check("bp_y", y, 28);
            check("bp_dbz", dbz, 0);
            check("bp_in_ready", in_ready, 0);
        end
        $display("op backpressure mode=0 a=200 b=7 -> y=%0d held 5 cycles", y);
        drain();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("bp_no_ghost_result", out_valid, 0);
        end

        // Reset during RUN cycle 3 discards the operation.
        check("rst_in_ready_before", in_ready, 1);
        mode = 2'd0; a = 8'd200; b = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_still_running", out_valid, 0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_dbz", dbz, 0);
        check("rst_in_ready", in_ready, 1);
        $display("op reset mid-run -> out_valid=%0d y=%0d in_ready=%0d", out_valid, y, in_ready);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("rst_no_stale_result", out_valid, 0);
        end
        op(2'd0, 8'd9, 8'd3, 8'd3, 1'b0, W);

        // Random sweep with biased divisors (zero, powers of two, general).
        for (int n = 0; n < 1500; n++) begin
            rm = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'(1) << $urandom_range(0, W - 1);
                2:       rb = {W{1'b1}};
                default: rb = W'($urandom);
            endcase
            op_model(rm, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
